// File: rtl/reg_file_pkg.sv
// Shared constants, address-legality helper and count-delta encoding for the
// multi-port register file and its pending-write scoreboard.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_ADDR_W = 5;

    // Net change of the pending-register count on one edge.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10
    } cnt_delta_e;

    // An address may be written/allocated unless it is the hardwired zero register.
    function automatic logic addr_legal(input logic [31:0] addr, input logic zero_reg);
        return (addr != 32'd0) || !zero_reg;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: per-register busy bits with flush > alloc > wb
// priority, per-port busy lookup, and an incrementally maintained busy count.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    input  logic                     flush_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic [ADDR_W:0]          busy_cnt_o
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic        ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_d;
    logic             wb_legal_s;
    logic             alloc_legal_s;
    logic             inc_s;
    logic             dec_s;
    cnt_delta_e       delta_s;

    assign wb_legal_s    = wb_en_i && addr_legal(32'(wb_addr_i), ZERO_EN);
    assign alloc_legal_s = alloc_en_i && addr_legal(32'(alloc_addr_i), ZERO_EN);

    // A wb only retires a busy register if the same register is not re-allocated this edge.
    assign inc_s = alloc_legal_s && !busy_q[alloc_addr_i];
    assign dec_s = wb_legal_s && busy_q[wb_addr_i] &&
                   !(alloc_legal_s && (alloc_addr_i == wb_addr_i));

    // Encode the net count change for this edge.
    always_comb begin
        case ({inc_s, dec_s})
            2'b10:   delta_s = CNT_INC;
            2'b01:   delta_s = CNT_DEC;
            default: delta_s = CNT_HOLD;
        endcase
    end

    // Next busy vector: flush beats alloc, alloc beats wb for the same register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (alloc_legal_s && (alloc_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wb_legal_s && (wb_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Next busy count from the encoded delta.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            case (delta_s)
                CNT_INC: cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                CNT_DEC: cnt_d = cnt_q - {{ADDR_W{1'b0}}, 1'b1};
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt_o = cnt_q;

    genvar k;
    for (k = 0; k < int'(NUM_RD); k++) begin : g_busy
        logic [ADDR_W-1:0] addr_s;
        assign addr_s = rd_addr_i[k*ADDR_W +: ADDR_W];
        // A same-cycle legal wb to the read address is bypassed, so it reads as ready.
        assign rd_busy_o[k] = busy_q[addr_s] && !(wb_legal_s && (wb_addr_i == addr_s));
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with same-cycle write-through bypass;
// pending-write tracking is delegated to reg_file_scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          busy_cnt_o
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic        ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wb_legal_s;

    assign wb_legal_s = wb_en_i && addr_legal(32'(wb_addr_i), ZERO_EN);

    // Next architectural state: only the legal wb destination changes.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wb_legal_s && (wb_addr_i == ADDR_W'(i))) begin
                regs_d[i] = wb_data_i;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage array; reset clears every register and overrides a same-cycle wb.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    genvar k;
    for (k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;

        assign addr_s = rd_addr_i[k*ADDR_W +: ADDR_W];

        // Read mux with write-through bypass; the hardwired zero register always reads 0.
        always_comb begin
            if (!addr_legal(32'(addr_s), ZERO_EN)) begin
                data_s = '0;
            end else if (wb_legal_s && (wb_addr_i == addr_s)) begin
                data_s = wb_data_i;
            end else begin
                data_s = regs_q[addr_s];
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data_s;
    end

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_addr_i    (rd_addr_i),
        .wb_en_i      (wb_en_i),
        .wb_addr_i    (wb_addr_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .flush_i      (flush_i),
        .rd_busy_o    (rd_busy_o),
        .busy_cnt_o   (busy_cnt_o)
    );

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port integer register file with same-cycle write-through bypass and a per-register pending-write scoreboard. It succeeds the fixed 32x64 two-read-port file in the decode stage of the pipelined core. The decode stage uses it for operand fetch and for RAW-hazard stall decisions. Writeback drives the write port; decode/issue drives the allocate port.

Parameters:
DATA_W, 64, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  read data, combinational, port k packed likewise
rd_busy_o  out  NUM_RD  1 = register on port k has a pending write not yet available
wb_en_i  in  1  writeback write enable
wb_addr_i  in  ADDR_W  writeback destination
wb_data_i  in  DATA_W  writeback data
alloc_en_i  in  1  issue marks a destination as pending
alloc_addr_i  in  ADDR_W  destination being allocated
flush_i  in  1  clear all pending bits (pipeline flush)
busy_cnt_o  out  ADDR_W+1  number of registers currently pending (registered)

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-high (rst_i), sampled on the rising edge.
- Reset: all registers 0, all busy bits 0, busy_cnt_o = 0. Reset overrides wb, alloc and flush in the same cycle.
- Write: on the edge with wb_en_i=1 and (wb_addr_i!=0 or ZERO_REG=0), regs[wb_addr_i] <= wb_data_i. Writes to reg 0 are dropped when ZERO_REG=1.
- Read: rd_data_o[k] is combinational, with zero-latency bypass.
  - If wb_en_i and wb_addr_i==rd_addr[k] and the write is legal, the output is wb_data_i.
  - Otherwise it is regs[rd_addr[k]].
  - Reg 0 reads 0 when ZERO_REG=1.
- Scoreboard, busy[] next-state priority (highest first):
  1. rst_i: all busy bits 0.
  2. flush_i: all busy bits 0. An alloc in the same cycle is discarded. A wb in the same cycle still writes data.
  3. Per register: if alloc_en_i hits it, busy=1. Alloc wins over a same-cycle wb to the same address, because the newer producer is outstanding.
  4. Else if a legal wb hits it, busy=0.
  5. Else busy holds.
  - Alloc to reg 0 is ignored when ZERO_REG=1.
  - Alloc to an already-busy register keeps it busy and the count is unchanged.
- rd_busy_o[k] = busy[rd_addr[k]] & ~(legal wb to the same address this cycle). A bypassed value counts as ready; the current cycle's alloc does not affect rd_busy_o until the next cycle.
- busy_cnt_o: registered population count of busy[], updated incrementally.
  - +1 for an alloc to a non-busy register.
  - -1 for a wb to a busy register not re-allocated this cycle.
  - Net 0 when both apply to different registers.
  - Flush sets it to 0.
  - It never exceeds 2**ADDR_W (or 2**ADDR_W-1 when ZERO_REG=1).
- Wb to a non-busy register is legal: data is written, busy stays 0, count unchanged.
- Read latency is 0 cycles. Write-to-architectural-state latency is 1 edge. Bypass removes the visible gap.

Decomposition:
- Shared package reg_file_pkg holds:
  - default DATA_W/ADDR_W constants
  - a function for the address-legal check (nonzero or ZERO_REG=0)
  - a popcount-free count-delta encoding (+1/0/-1) enum
- One sub-module, reg_file_scoreboard, holds the busy[] vector, the busy_cnt logic, and the flush/alloc/wb priority. The top level holds the storage array, the read muxes and the bypass.

Test Plan:
- Reset with rst_i=1 for 2 cycles while wb_en_i=1, addr 3, data 0xAA -> after release, reads of x3 return 0; busy_cnt_o=0; rd_busy_o=0.
- Write x5=0x1234 with rd_addr port0=5 in the same cycle -> rd_data_o port0=0x1234 combinationally; next cycle without wb still 0x1234.
- Write x0=0xFFFF and alloc x0 (ZERO_REG=1) -> x0 reads 0; busy_cnt_o stays 0; rd_busy_o for x0 stays 0.
- Alloc x7 -> next cycle rd_busy_o=1 for x7 and busy_cnt_o=1. Then wb x7=0x55 -> same cycle rd_busy_o=0, data 0x55; next cycle busy_cnt_o=0.
- Alloc x9 and wb x9 in the same cycle -> x9 remains busy and busy_cnt_o=1. Alloc x10 with flush_i=1 -> next cycle all busy 0 and busy_cnt_o=0.
- NUM_RD=4 with all ports reading x12 during wb x12=0xDEAD -> all four ports return 0xDEAD with rd_busy_o=4'b0000.
